seg_scan_capture: RTL

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

---
 rtl/seg_scan_capture.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seg_scan_capture.sv
// Captures a multiplexed 8-digit active-low 7-segment scan into a 32-bit hex value.
// A digit is taken after its {AN,SEG} pattern has been stable for STABLE samples.
module seg_scan_capture #(
    parameter int STABLE = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  SEG,
    input  logic [7:0]  AN,
    output logic [31:0] value,
    output logic [7:0]  dp,
    output logic        frame_valid,
    output logic        bad_glyph,
    output logic        an_err
);

    typedef enum logic {WAIT, HOLD} state_t;

    state_t      state;
    logic [7:0]  seg_s, an_s, seg_p, an_p;
    logic [7:0]  cnt;
    logic [7:0]  mask;
    logic [31:0] stage_nib;
    logic [7:0]  stage_dp;
    logic [7:0]  stage_bad;

    logic        changed, act, one_hot, capture, multi;
    logic [7:0]  zeros, sel, mask_base, bad_base, mask_n, bad_n;
    logic [2:0]  digit_idx;
    logic [3:0]  nib;
    logic        glyph_bad;

    always_comb begin
        changed   = {an_s, seg_s} != {an_p, seg_p};
        act       = (state == WAIT) && !changed && (cnt == 8'(STABLE - 1));
        zeros     = ~an_s;
        one_hot   = (zeros != 8'h00) && ((zeros & (zeros - 8'd1)) == 8'h00);
        capture   = act && one_hot;
        multi     = act && (zeros != 8'h00) && !one_hot;
        digit_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (zeros[i]) digit_idx = 3'(i);
        end
        sel = 8'd1 << digit_idx;
    end

    always_comb begin
        glyph_bad = 1'b0;
        case (seg_s[6:0])
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: begin
                nib       = 4'h0;
                glyph_bad = 1'b1;
            end
        endcase
    end

    // A full mask is committed this cycle, so a coincident capture starts the next frame.
    always_comb begin
        mask_base = (mask == 8'hFF) ? 8'h00 : mask;
        bad_base  = (mask == 8'hFF) ? 8'h00 : stage_bad;
        mask_n    = capture ? (mask_base | sel) : mask_base;
        bad_n     = capture ? ((bad_base & ~sel) | (glyph_bad ? sel : 8'h00)) : bad_base;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            seg_s       <= 8'hFF;
            an_s        <= 8'hFF;
            seg_p       <= 8'hFF;
            an_p        <= 8'hFF;
            cnt         <= 8'd0;
            state       <= WAIT;
            mask        <= 8'h00;
            stage_nib   <= 32'h0;
            stage_dp    <= 8'h00;
            stage_bad   <= 8'h00;
            value       <= 32'h0;
            dp          <= 8'h00;
            frame_valid <= 1'b0;
            bad_glyph   <= 1'b0;
            an_err      <= 1'b0;
        end else begin
            seg_s <= SEG;
            an_s  <= AN;
            seg_p <= seg_s;
            an_p  <= an_s;

            if (changed)                   cnt <= 8'd0;
            else if (cnt != 8'(STABLE))    cnt <= cnt + 8'd1;

            case (state)
                WAIT:    if (act)     state <= HOLD;
                HOLD:    if (changed) state <= WAIT;
                default:              state <= WAIT;
            endcase

            if (capture) begin
                stage_nib[4*digit_idx +: 4] <= nib;
                stage_dp[digit_idx]         <= ~seg_s[7];
            end
            mask      <= mask_n;
            stage_bad <= bad_n;

            frame_valid <= (mask == 8'hFF);
            if (mask == 8'hFF) begin
                value     <= stage_nib;
                dp        <= stage_dp;
                bad_glyph <= |stage_bad;
            end

            an_err <= multi;
        end
    end

endmodule
